// File: rtl/cpu_isa_pkg.sv
// cpu_isa_pkg: ISA type-field constants, shift-immediate op-code check and decoded-control struct.
package cpu_isa_pkg;
    localparam logic [5:0] RTYPE = 6'b101010;
    localparam logic [5:0] VLD   = 6'b100000;
    localparam logic [5:0] VSD   = 6'b100001;
    localparam logic [5:0] VBEZ  = 6'b100010;
    localparam logic [5:0] VBNEZ = 6'b100011;
    localparam logic [5:0] VNOP  = 6'b111100;

    // Shift-immediate R-type ops reuse the rB slot, so a non-zero rB there is malformed.
    function automatic logic is_shift_op(input logic [5:0] op);
        return op inside {6'b000100, 6'b000101, 6'b001101, 6'b010000, 6'b010001, 6'b010010};
    endfunction

    typedef struct packed {
        logic wr_en;
        logic mem_en;
        logic memwr_en;
        logic bez;
        logic bnez;
        logic rd_as_source;
        logic illegal;
    } ctrl_t;
endpackage

// File: rtl/inst_decode_comb.sv
// inst_decode_comb: pure combinational decode of one big-endian instruction.
//   inst          instruction, bit 0 is the MSB as in the ISA
//   ctrl          decoded control struct
//   rd/ra/rb/ww/ppp/imm/op  extracted fields
//   src_a/src_b/src_d  register fields this instruction reads
//   is_load       instruction is a VLD (writes rD through the load path)
module inst_decode_comb
    import cpu_isa_pkg::*;
(
    input  logic [0:31] inst,
    output ctrl_t       ctrl,
    output logic [4:0]  rd,
    output logic [4:0]  ra,
    output logic [4:0]  rb,
    output logic [1:0]  ww,
    output logic [2:0]  ppp,
    output logic [15:0] imm,
    output logic [5:0]  op,
    output logic        src_a,
    output logic        src_b,
    output logic        src_d,
    output logic        is_load
);
    logic [5:0] kind;
    logic       ra_zero;
    logic       shift_bad;

    assign kind      = inst[0:5];
    assign rd        = inst[6:10];
    assign ra        = inst[11:15];
    assign rb        = inst[16:20];
    assign ppp       = inst[21:23];
    assign ww        = inst[24:25];
    assign op        = inst[26:31];
    assign imm       = inst[16:31];
    assign ra_zero   = ra == 5'd0;
    assign shift_bad = is_shift_op(op) && rb != 5'd0;

    always_comb begin
        ctrl    = '0;
        src_a   = 1'b0;
        src_b   = 1'b0;
        src_d   = 1'b0;
        is_load = 1'b0;
        case (kind)
            RTYPE: begin
                ctrl.wr_en        = !shift_bad;
                ctrl.rd_as_source = !shift_bad;
                ctrl.illegal      = shift_bad;
                src_a             = 1'b1;
                src_b             = 1'b1;
            end
            VLD: begin
                ctrl.mem_en  = ra_zero;
                ctrl.illegal = !ra_zero;
                is_load      = 1'b1;
            end
            VSD: begin
                ctrl.mem_en   = ra_zero;
                ctrl.memwr_en = ra_zero;
                ctrl.illegal  = !ra_zero;
                src_d         = 1'b1;
            end
            VBEZ: begin
                ctrl.bez     = ra_zero;
                ctrl.illegal = !ra_zero;
                src_d        = 1'b1;
            end
            VBNEZ: begin
                ctrl.bnez    = ra_zero;
                ctrl.illegal = !ra_zero;
                src_d        = 1'b1;
            end
            VNOP:    ctrl = '0;
            default: ctrl.illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/decode_pipe_ctrl.sv
// decode_pipe_ctrl: registered ID stage with valid/ready intake, ID/EX register and load scoreboard.
//   clk, reset_n (async active-low)
//   if_valid/if_inst/if_ready   intake handshake from IF
//   ex_ready                    EX consumes the ID register
//   flush                       kill ID contents and refuse input
//   wb_valid/wb_rd              load writeback, clears a pending scoreboard bit
//   id_*                        registered decode outputs, id_valid marks a live instruction
//   stall_cnt                   saturating count of hazard-stall cycles
// Define DECODE_SCOREBOARD_EN to build the scoreboard and hazard stall; otherwise hazard is 0.
module decode_pipe_ctrl
    import cpu_isa_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
)
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_valid,
    input  logic [0:31]           if_inst,
    output logic                  if_ready,
    input  logic                  ex_ready,
    input  logic                  flush,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  id_valid,
    output logic                  id_wrEn,
    output logic                  id_memEn,
    output logic                  id_memwrEn,
    output logic                  id_bez,
    output logic                  id_bnez,
    output logic                  id_rD_as_source,
    output logic                  id_illegal,
    output logic [REG_ADDR_W-1:0] id_rD,
    output logic [REG_ADDR_W-1:0] id_rA,
    output logic [REG_ADDR_W-1:0] id_rB,
    output logic [1:0]            id_WW,
    output logic [2:0]            id_ppp,
    output logic [15:0]           id_imm,
    output logic [5:0]            id_op_code,
    output logic [CNT_W-1:0]      stall_cnt
);
    ctrl_t       d_ctrl;
    logic [4:0]  d_rd, d_ra, d_rb;
    logic [1:0]  d_ww;
    logic [2:0]  d_ppp;
    logic [15:0] d_imm;
    logic [5:0]  d_op;
    logic        d_src_a, d_src_b, d_src_d, d_load;
    logic        hazard, accept, handoff;

    inst_decode_comb u_dec (
        .inst(if_inst), .ctrl(d_ctrl), .rd(d_rd), .ra(d_ra), .rb(d_rb), .ww(d_ww),
        .ppp(d_ppp), .imm(d_imm), .op(d_op), .src_a(d_src_a), .src_b(d_src_b),
        .src_d(d_src_d), .is_load(d_load)
    );

    assign if_ready = reset_n && (!id_valid || ex_ready) && !hazard && !flush;
    assign accept   = if_valid && if_ready;
    assign handoff  = id_valid && ex_ready && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_valid        <= 1'b0;
            id_wrEn         <= 1'b0;
            id_memEn        <= 1'b0;
            id_memwrEn      <= 1'b0;
            id_bez          <= 1'b0;
            id_bnez         <= 1'b0;
            id_rD_as_source <= 1'b0;
            id_illegal      <= 1'b0;
            id_rD           <= '0;
            id_rA           <= '0;
            id_rB           <= '0;
            id_WW           <= '0;
            id_ppp          <= '0;
            id_imm          <= '0;
            id_op_code      <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (accept) begin
            id_valid        <= 1'b1;
            id_wrEn         <= d_ctrl.wr_en;
            id_memEn        <= d_ctrl.mem_en;
            id_memwrEn      <= d_ctrl.memwr_en;
            id_bez          <= d_ctrl.bez;
            id_bnez         <= d_ctrl.bnez;
            id_rD_as_source <= d_ctrl.rd_as_source;
            id_illegal      <= d_ctrl.illegal;
            id_rD           <= d_rd;
            id_rA           <= d_ra;
            id_rB           <= d_rb;
            id_WW           <= d_ww;
            id_ppp          <= d_ppp;
            id_imm          <= d_imm;
            id_op_code      <= d_op;
        end else if (handoff) begin
            id_valid <= 1'b0;
        end
    end

`ifdef DECODE_SCOREBOARD_EN
    localparam logic [NUM_REGS-1:0] ONE = NUM_REGS'(1);
    logic [NUM_REGS-1:0] sb, pend, set_vec, clr_vec;
    logic                id_load;

    // A legal VLD is the only instruction with memEn set and memwrEn clear.
    assign id_load = id_memEn && !id_memwrEn;

    always_comb begin
        set_vec = (handoff && id_load) ? ONE << id_rD : '0;
        clr_vec = wb_valid ? ONE << wb_rd : '0;
        // The VLD sitting in ID counts as pending even though its bit is not yet set.
        pend    = sb | ((id_valid && id_load) ? ONE << id_rD : '0);
        hazard  = !d_ctrl.illegal && ((d_src_a && pend[d_ra]) || (d_src_b && pend[d_rb]) ||
                  ((d_src_d || d_load) && pend[d_rd]));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sb        <= '0;
            stall_cnt <= '0;
        end else begin
            sb <= (sb & ~clr_vec) | set_vec;
            if (if_valid && hazard && !flush && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    logic unused_sb;

    assign hazard    = 1'b0;
    assign stall_cnt = '0;
    assign unused_sb = ^{wb_valid, wb_rd, d_src_a, d_src_b, d_src_d, d_load};
`endif
endmodule

// File: tb/tb_decode_pipe_ctrl.sv
// tb_decode_pipe_ctrl: directed self-checking bench for decode_pipe_ctrl.
module tb_decode_pipe_ctrl;
    import cpu_isa_pkg::*;
`ifdef DECODE_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_valid, if_ready, ex_ready, flush, wb_valid;
    logic [0:31] if_inst;
    logic [4:0]  wb_rd;
    logic        id_valid, id_wrEn, id_memEn, id_memwrEn, id_bez, id_bnez, id_rD_as_source, id_illegal;
    logic [4:0]  id_rD, id_rA, id_rB;
    logic [1:0]  id_WW;
    logic [2:0]  id_ppp;
    logic [15:0] id_imm;
    logic [5:0]  id_op_code;
    logic [15:0] stall_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;

    decode_pipe_ctrl dut (
        .clk(clk), .reset_n(reset_n), .if_valid(if_valid), .if_inst(if_inst), .if_ready(if_ready),
        .ex_ready(ex_ready), .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .id_valid(id_valid), .id_wrEn(id_wrEn), .id_memEn(id_memEn), .id_memwrEn(id_memwrEn),
        .id_bez(id_bez), .id_bnez(id_bnez), .id_rD_as_source(id_rD_as_source),
        .id_illegal(id_illegal), .id_rD(id_rD), .id_rA(id_rA), .id_rB(id_rB), .id_WW(id_WW),
        .id_ppp(id_ppp), .id_imm(id_imm), .id_op_code(id_op_code), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] r_inst(input logic [4:0] rd, ra, rb, input logic [5:0] op);
        return {RTYPE, rd, ra, rb, 3'b000, 2'b00, op};
    endfunction

    function automatic logic [31:0] m_inst(input logic [5:0] t, input logic [4:0] rd, ra, input logic [15:0] imm);
        return {t, rd, ra, imm};
    endfunction

    initial begin
        reset_n = 1'b0; if_valid = 1'b1; if_inst = '0; ex_ready = 1'b1;
        flush = 1'b0; wb_valid = 1'b0; wb_rd = '0;
        #12;
        chk("rst_valid", id_valid, 0);
        chk("rst_ready", if_ready, 0);
        chk("rst_cnt", stall_cnt, 0);
        if_valid = 1'b0;
        tick;
        reset_n = 1'b1;
        // back-to-back RTYPE then VSD
        if_valid = 1'b1; if_inst = r_inst(5'd3, 5'd1, 5'd2, 6'b000000);
        #1 chk("t1_ready", if_ready, 1);
        tick;
        chk("t1_valid", id_valid, 1);
        chk("t1_wren", id_wrEn, 1);
        chk("t1_rdsrc", id_rD_as_source, 1);
        chk("t1_rd", id_rD, 3);
        if_inst = m_inst(VSD, 5'd7, 5'd0, 16'h0040);
        tick;
        chk("t1_vsd_valid", id_valid, 1);
        chk("t1_memen", id_memEn, 1);
        chk("t1_memwr", id_memwrEn, 1);
        chk("t1_imm", id_imm, 16'h0040);
        chk("t1_vsd_wren", id_wrEn, 0);
        if_valid = 1'b0;
        tick;
        chk("t1_drain", id_valid, 0);
        // RAW on a handed-off load, released by writeback
        if_valid = 1'b1; if_inst = m_inst(VLD, 5'd5, 5'd0, 16'h0000);
        tick;
        chk("t2_vld_memen", id_memEn, 1);
        if_inst = r_inst(5'd1, 5'd5, 5'd0, 6'b000000);
        #1 chk("t2_ready0", if_ready, SB ? 0 : 1);
        tick;
        chk("t2_cnt1", stall_cnt, SB ? 1 : 0);
        tick;
        chk("t2_cnt2", stall_cnt, SB ? 2 : 0);
        wb_valid = 1'b1; wb_rd = 5'd5;
        #1 chk("t2_nobypass", if_ready, SB ? 0 : 1);
        tick;
        wb_valid = 1'b0;
        #1 chk("t2_released", if_ready, 1);
        chk("t2_cnt3", stall_cnt, SB ? 3 : 0);
        tick;
        chk("t2_ra", id_rA, 5);
        chk("t2_wren", id_wrEn, 1);
        if_valid = 1'b0;
        tick;
        // WAW against a VLD held in ID
        ex_ready = 1'b0; if_valid = 1'b1; if_inst = m_inst(VLD, 5'd4, 5'd0, 16'h0000);
        tick;
        chk("t3_rd", id_rD, 4);
        tick;
        chk("t3_cnt4", stall_cnt, SB ? 4 : 0);
        chk("t3_hold", id_rD, 4);
        ex_ready = 1'b1;
        #1 chk("t3_waw", if_ready, SB ? 0 : 1);
        tick;
        wb_valid = 1'b1; wb_rd = 5'd4;
        tick;
        wb_valid = 1'b0;
        #1 chk("t3_released", if_ready, 1);
        chk("t3_cnt6", stall_cnt, SB ? 6 : 0);
        tick;
        chk("t3_valid", id_valid, 1);
        chk("t3_memen", id_memEn, 1);
        if_valid = 1'b0;
        tick;
        wb_valid = 1'b1; wb_rd = 5'd4;
        tick;
        wb_valid = 1'b0;
        // illegal encodings and a legal branch
        if_valid = 1'b1; if_inst = r_inst(5'd1, 5'd0, 5'd3, 6'b000100);
        tick;
        chk("t4_sh_ill", id_illegal, 1);
        chk("t4_sh_wren", id_wrEn, 0);
        if_inst = m_inst(VBEZ, 5'd0, 5'd2, 16'h0000);
        tick;
        chk("t4_bez_ill", id_illegal, 1);
        chk("t4_bez_off", id_bez, 0);
        if_inst = m_inst(VBEZ, 5'd6, 5'd0, 16'h0010);
        tick;
        chk("t4_bez_on", id_bez, 1);
        chk("t4_bez_legal", id_illegal, 0);
        chk("t4_bez_imm", id_imm, 16'h0010);
        if_valid = 1'b0;
        tick;
        // flush a held VLD; its register must not be marked pending
        ex_ready = 1'b0; if_valid = 1'b1; if_inst = m_inst(VLD, 5'd9, 5'd0, 16'h0000);
        tick;
        chk("t5_rd", id_rD, 9);
        if_valid = 1'b0; flush = 1'b1;
        #1 chk("t5_flush_ready", if_ready, 0);
        tick;
        flush = 1'b0;
        chk("t5_killed", id_valid, 0);
        ex_ready = 1'b1; if_valid = 1'b1; if_inst = r_inst(5'd2, 5'd9, 5'd0, 6'b000000);
        #1 chk("t5_no_stall", if_ready, 1);
        tick;
        chk("t5_ra", id_rA, 9);
        chk("t5_cnt", stall_cnt, SB ? 6 : 0);
        if_valid = 1'b0;
        tick;
        // reset while stalled on three pending loads
        if_valid = 1'b1; if_inst = m_inst(VLD, 5'd10, 5'd0, 16'h0000);
        tick;
        if_inst = m_inst(VLD, 5'd11, 5'd0, 16'h0000);
        tick;
        if_inst = m_inst(VLD, 5'd12, 5'd0, 16'h0000);
        tick;
        if_valid = 1'b0;
        tick;
        if_valid = 1'b1; if_inst = r_inst(5'd1, 5'd10, 5'd11, 6'b000000);
        #1 chk("t6_stall", if_ready, SB ? 0 : 1);
        tick;
        chk("t6_cnt7", stall_cnt, SB ? 7 : 0);
        #1 reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", id_valid, 0);
        chk("t6_rst_cnt", stall_cnt, 0);
        chk("t6_rst_ready", if_ready, 0);
        chk("t6_rst_rd", id_rD, 0);
        chk("t6_rst_memen", id_memEn, 0);
        tick;
        reset_n = 1'b1;
        if_inst = r_inst(5'd3, 5'd12, 5'd11, 6'b000000);
        #1 chk("t6_post_ready", if_ready, 1);
        tick;
        chk("t6_post_valid", id_valid, 1);
        chk("t6_post_ra", id_rA, 12);
        chk("t6_post_cnt", stall_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
